ctrl_seq: RTL

Parametrised multi-cycle control sequencer for the processor core. It fetches 16-bit instructions over a variable-latency req/ack memory port, decodes the 4-bit opcode ISA, and drives the register file and ALU. It replaces fixed SRAM wait-state sequencing with a handshake and adds configurable data/address widths, a run/idle gate, halt detection and illegal-opcode flagging.

---
 rtl/ctrl_seq_pkg.sv | 76 +++++++
 rtl/ctrl_seq_decode.sv | 93 +++++++++
 rtl/ctrl_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: ISA opcodes, ALU op codes, FSM states, instruction classes and field positions
// shared by the sequencer top and its decoder.
package ctrl_seq_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OP3_MSB = 11;
  localparam int OP3_LSB = 8;
  localparam int OP2_MSB = 7;
  localparam int OP2_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;
  localparam int JMP_MSB = 11;
  localparam int JMP_LSB = 0;
  localparam int JMP_W   = JMP_MSB - JMP_LSB + 1;

  localparam logic [3:0] REG_NONE = 4'hf;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'd0,
    OPC_ADDI = 4'd1,
    OPC_SUB  = 4'd2,
    OPC_SUBI = 4'd3,
    OPC_MULT = 4'd4,
    OPC_SW   = 4'd5,
    OPC_LW   = 4'd6,
    OPC_LT   = 4'd7,
    OPC_NAND = 4'd8,
    OPC_DIV  = 4'd9,
    OPC_MOD  = 4'd10,
    OPC_LTE  = 4'd11,
    OPC_BLT  = 4'd12,
    OPC_BLE  = 4'd13,
    OPC_BEQ  = 4'd14,
    OPC_JUMP = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_MULT = 3'd2,
    ALU_NAND = 3'd3,
    ALU_DIV  = 3'd4,
    ALU_MOD  = 3'd5,
    ALU_LT   = 3'd6,
    ALU_LTE  = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,
    CLS_MEM    = 2'd1,
    CLS_BRANCH = 2'd2
  } instr_cls_e;

  function automatic alu_op_e muldiv_alu_op(input opcode_e opc);
    case (opc)
      OPC_DIV: return ALU_DIV;
      OPC_MOD: return ALU_MOD;
      default: return ALU_MULT;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode: purely combinational instruction field extraction and classification.
// MULT/DIV/MOD are legal only when CTRL_SEQ_MULDIV_EN is defined; otherwise they flag illegal.
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [3:0]         op3_o,
  output logic [3:0]         op2_o,
  output logic [3:0]         imm_o,
  output logic [JMP_W-1:0]   jump_o,
  output logic [3:0]         reg_addr_a_o,
  output logic [3:0]         reg_addr_b_o,
  output logic [3:0]         reg_addr_c_o,
  output instr_cls_e         cls_o,
  output alu_op_e            alu_op_o,
  output logic               im_en_o,
  output logic               is_store_o,
  output logic               is_jump_o,
  output logic               br_eq_o,
  output logic               illegal_o
);

  opcode_e opcode;

  assign opcode       = opcode_e'(instr_i[OPC_MSB:OPC_LSB]);
  assign op3_o        = instr_i[OP3_MSB:OP3_LSB];
  assign op2_o        = instr_i[OP2_MSB:OP2_LSB];
  assign imm_o        = instr_i[IMM_MSB:IMM_LSB];
  assign jump_o       = instr_i[JMP_MSB:JMP_LSB];
  assign reg_addr_a_o = instr_i[IMM_MSB:IMM_LSB];
  assign reg_addr_b_o = instr_i[OP2_MSB:OP2_LSB];
  assign reg_addr_c_o = instr_i[OP3_MSB:OP3_LSB];

  always_comb begin
    cls_o      = CLS_ALU;
    alu_op_o   = ALU_ADD;
    im_en_o    = 1'b0;
    is_store_o = 1'b0;
    is_jump_o  = 1'b0;
    br_eq_o    = 1'b0;
    illegal_o  = 1'b0;
    case (opcode)
      OPC_ADD:  alu_op_o = ALU_ADD;
      OPC_ADDI: begin
        alu_op_o = ALU_ADD;
        im_en_o  = 1'b1;
      end
      OPC_SUB:  alu_op_o = ALU_SUB;
      OPC_SUBI: begin
        alu_op_o = ALU_SUB;
        im_en_o  = 1'b1;
      end
      OPC_MULT, OPC_DIV, OPC_MOD: begin
`ifdef CTRL_SEQ_MULDIV_EN
        alu_op_o = muldiv_alu_op(opcode);
`else
        illegal_o = 1'b1;
`endif
      end
      OPC_SW: begin
        cls_o      = CLS_MEM;
        im_en_o    = 1'b1;
        is_store_o = 1'b1;
      end
      OPC_LW: begin
        cls_o   = CLS_MEM;
        im_en_o = 1'b1;
      end
      OPC_LT:   alu_op_o = ALU_LT;
      OPC_NAND: alu_op_o = ALU_NAND;
      OPC_LTE:  alu_op_o = ALU_LTE;
      OPC_BLT: begin
        cls_o    = CLS_BRANCH;
        alu_op_o = ALU_LT;
      end
      OPC_BLE: begin
        cls_o    = CLS_BRANCH;
        alu_op_o = ALU_LTE;
      end
      OPC_BEQ: begin
        cls_o    = CLS_BRANCH;
        alu_op_o = ALU_SUB;
        br_eq_o  = 1'b1;
      end
      OPC_JUMP: begin
        cls_o     = CLS_BRANCH;
        is_jump_o = 1'b1;
      end
      default: cls_o = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetch/decode/execute sequencer; 3 cycles per ALU/SW/branch, 4 per LW, +1 per memory wait state.
// Requests are held stable until mem_ack; build option CTRL_SEQ_MULDIV_EN enables MULT/DIV/MOD.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        reg_addr_a,
  output logic [3:0]        reg_addr_b,
  output logic [3:0]        reg_addr_c,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_data_c,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_op_a,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_status,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done;

  logic [3:0]          dec_op3, dec_op2, dec_imm;
  logic [JMP_W-1:0]    dec_jump;
  logic [3:0]          dec_ra, dec_rb, dec_rc;
  instr_cls_e          dec_cls;
  alu_op_e             dec_alu_op;
  logic                dec_im_en, dec_store, dec_jmp, dec_br_eq, dec_illegal;

  logic [ADDR_W-1:0]   pc_inc, br_target, jump_off, jump_target;
  logic [DATA_W-1:0]   imm_ext;
  logic                br_taken;

  ctrl_seq_decode u_decode (
    .instr_i      (instr_q),
    .op3_o        (dec_op3),
    .op2_o        (dec_op2),
    .imm_o        (dec_imm),
    .jump_o       (dec_jump),
    .reg_addr_a_o (dec_ra),
    .reg_addr_b_o (dec_rb),
    .reg_addr_c_o (dec_rc),
    .cls_o        (dec_cls),
    .alu_op_o     (dec_alu_op),
    .im_en_o      (dec_im_en),
    .is_store_o   (dec_store),
    .is_jump_o    (dec_jmp),
    .br_eq_o      (dec_br_eq),
    .illegal_o    (dec_illegal)
  );

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign br_target   = pc_inc + ADDR_W'(dec_imm);
  assign jump_off    = ADDR_W'($signed(dec_jump));
  assign jump_target = pc_q + jump_off;
  assign imm_ext     = DATA_W'(dec_imm);
  // BEQ compares by subtraction (zero = equal); BLT/BLE report the compare result as 1.
  assign br_taken    = dec_br_eq ? (alu_status == '0) : (alu_status == DATA_W'(1));

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    data_d     = data_q;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    reg_addr_a = REG_NONE;
    reg_addr_b = REG_NONE;
    reg_addr_c = REG_NONE;
    reg_we     = 1'b0;
    reg_data_c = '0;
    alu_op     = ALU_ADD;
    alu_op_a   = '0;
    illegal    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!run_n) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          instr_d = mem_rdata[INSTR_W-1:0];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_MEM:    state_d = ST_MEM;
          CLS_BRANCH: state_d = ST_BRANCH;
          default:    state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        reg_addr_a = dec_ra;
        reg_addr_b = dec_rb;
        reg_addr_c = dec_rc;
        alu_op     = dec_alu_op;
        alu_op_a   = dec_im_en ? imm_ext : reg_a;
        reg_we     = !dec_illegal;
        reg_data_c = alu_out;
        illegal    = dec_illegal;
        pc_d       = pc_inc;
        done       = 1'b1;
      end
      ST_MEM: begin
        // Effective address is formed by the external ALU: imm + reg[op2].
        alu_op     = ALU_ADD;
        alu_op_a   = imm_ext;
        reg_addr_b = dec_op2;
        mem_req    = 1'b1;
        mem_addr   = alu_out[ADDR_W-1:0];
        if (dec_store) begin
          mem_we     = 1'b1;
          reg_addr_a = dec_op3;
          mem_wdata  = reg_a;
        end
        if (mem_ack) begin
          if (dec_store) begin
            pc_d = pc_inc;
            done = 1'b1;
          end else begin
            data_d  = mem_rdata;
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_addr_c = dec_rc;
        reg_we     = 1'b1;
        reg_data_c = data_q;
        pc_d       = pc_inc;
        done       = 1'b1;
      end
      ST_BRANCH: begin
        reg_addr_a = dec_op3;
        reg_addr_b = dec_op2;
        alu_op     = dec_alu_op;
        alu_op_a   = reg_a;
        if (dec_jmp) begin
          if (dec_jump == '0) begin
            state_d = ST_HALT;
          end else begin
            pc_d = jump_target;
            done = 1'b1;
          end
        end else begin
          pc_d = br_taken ? br_target : pc_inc;
          done = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) state_d = run_n ? ST_IDLE : ST_FETCH;
  end

endmodule
